// File: rtl/lc3_mem_io.sv
// LC-3 memory and I/O block: word RAM, memory-mapped keyboard/display
// registers and the machine control register that gates the processor clock.
module lc3_mem_io #(
  parameter int RAM_AW = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] din,
  input  logic        memWE,
  output logic [15:0] dout,
  input  logic [7:0]  kbd_data,
  input  logic        kbd_valid,
  output logic        kbd_ready,
  output logic [7:0]  disp_data,
  output logic        disp_valid,
  input  logic        disp_ready,
  output logic        run
);

  localparam logic [15:0] DEV_BASE = 16'hFE00;
  localparam logic [15:0] KBSR_A   = 16'hFE00;
  localparam logic [15:0] KBDR_A   = 16'hFE02;
  localparam logic [15:0] DSR_A    = 16'hFE04;
  localparam logic [15:0] DDR_A    = 16'hFE06;
  localparam logic [15:0] MCR_A    = 16'hFFFE;

  logic [15:0]       mem_r [0:(2**RAM_AW)-1];
  logic [RAM_AW-1:0] ram_idx_s;
  logic              is_ram_s;
  logic              ram_we_s;

  logic [15:0] prev_addr_r;
  logic        prev_vld_r;
  logic        kbdr_access_s;

  logic        kbd_full_r;
  logic [7:0]  kbd_char_r;
  logic        kbd_capture_s;
  logic        disp_valid_r;
  logic [7:0]  disp_data_r;
  logic        disp_load_s;
  logic        run_r;

  assign ram_idx_s = addr[RAM_AW-1:0];
  assign is_ram_s  = (addr < DEV_BASE);
  assign ram_we_s  = memWE & is_ram_s;

  // A KBDR read consumes the character only on the first cycle the address lands there.
  assign kbdr_access_s = (addr == KBDR_A) && !memWE &&
                         (!prev_vld_r || (addr != prev_addr_r));
  assign kbd_capture_s = kbd_valid & ~kbd_full_r;
  assign disp_load_s   = memWE && (addr == DDR_A) && !disp_valid_r;

  assign kbd_ready  = ~kbd_full_r;
  assign disp_data  = disp_data_r;
  assign disp_valid = disp_valid_r;
  assign run        = run_r;

  // RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      mem_r[ram_idx_s] <= din;
    end
  end

  // Previous-address tracker for KBDR access detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_addr_r <= 16'h0000;
      prev_vld_r  <= 1'b0;
    end else begin
      prev_addr_r <= addr;
      prev_vld_r  <= 1'b1;
    end
  end

  // Keyboard holding register; capture has priority over the read-clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      kbd_full_r <= 1'b0;
      kbd_char_r <= 8'h00;
    end else if (kbd_capture_s) begin
      kbd_full_r <= 1'b1;
      kbd_char_r <= kbd_data;
    end else if (kbdr_access_s) begin
      kbd_full_r <= 1'b0;
    end
  end

  // Display output register and handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_valid_r <= 1'b0;
      disp_data_r  <= 8'h00;
    end else if (disp_valid_r && disp_ready) begin
      disp_valid_r <= 1'b0;
    end else if (disp_load_s) begin
      disp_valid_r <= 1'b1;
      disp_data_r  <= din[7:0];
    end
  end

  // Machine control register: only bit 15 (clock enable) is implemented.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_r <= 1'b1;
    end else if (memWE && (addr == MCR_A)) begin
      run_r <= din[15];
    end
  end

  // Read data multiplexer.
  always_comb begin
    dout = 16'h0000;
    if (is_ram_s) begin
      dout = mem_r[ram_idx_s];
    end else begin
      case (addr)
        KBSR_A:  dout = {kbd_full_r, 15'b0};
        KBDR_A:  dout = {8'h00, kbd_char_r};
        DSR_A:   dout = {~disp_valid_r, 15'b0};
        DDR_A:   dout = {8'h00, disp_data_r};
        MCR_A:   dout = {run_r, 15'b0};
        default: dout = 16'h0000;
      endcase
    end
  end

endmodule
